// File: rtl/k_float2fix_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : k_float2fix_seq_if
// Purpose  : valid/ready input and output channels of the float-to-fixed converter.
// Revision : 1.0
// ============================================================================
interface k_float2fix_seq_if #(
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/k_float2fix_seq.sv
`default_nettype none
// ============================================================================
// Module   : k_float2fix_seq
// Purpose  : IEEE-754 single to signed fixed point (FRAC_W fraction bits),
//            aligning the mantissa one bit per cycle. Optional macro
//            K_FLOAT2FIX_RNE_EN selects round-half-to-even over truncation.
// Revision : 1.0
// ============================================================================
module k_float2fix_seq #(
  parameter int OUT_W  = 32,
  parameter int FRAC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  k_float2fix_seq_if.slave bus_io
);

  localparam logic [OUT_W-1:0]   MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]   MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [10:0] S_BIAS  = 11'(FRAC_W - 150);
  localparam logic signed [10:0] S_MAX   = 11'(OUT_W - 25);
  localparam logic signed [10:0] S_EXACT = 11'(OUT_W - 24);
  localparam logic signed [10:0] S_RMAX  = 11'(-25);
  localparam logic [5:0]         N_RMAX  = 6'd25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       word_q, word_d;
  logic [OUT_W-1:0]  mag_q, mag_d;
  logic              sign_q, sign_d;
  logic              left_q, left_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic              ovf_q, ovf_d;

  logic [7:0]        exp_w;
  logic [22:0]       frac_w;
  logic signed [10:0] s_w;
  logic              in_shift;
  logic [OUT_W-1:0]  mag_load;
  logic [OUT_W-1:0]  mag_shift;
  logic [OUT_W-1:0]  fin_mag;
  logic              fin_sign;
  logic [OUT_W-1:0]  fin_data;
  logic              fin_ovf;

  assign exp_w     = word_q[30:23];
  assign frac_w    = word_q[22:0];
  assign s_w       = $signed({3'b000, exp_w}) + S_BIAS;
  assign in_shift  = (state_q == ST_SHIFT);
  assign mag_load  = OUT_W'({1'b1, frac_w});
  assign mag_shift = left_q ? (mag_q << 1) : (mag_q >> 1);

  // Final magnitude comes from the last shift, or straight from LOAD when n=0.
  assign fin_mag   = in_shift ? mag_shift : mag_load;
  assign fin_sign  = in_shift ? sign_q : word_q[31];

`ifdef K_FLOAT2FIX_RNE_EN
  logic             guard_q, guard_d;
  logic             sticky_q, sticky_d;
  logic             guard_shift, sticky_shift;
  logic             fin_guard, fin_sticky, rnd_up, rnd_ovf;
  logic [OUT_W:0]   mag_rnd;

  assign guard_shift  = ~left_q & mag_q[0];
  assign sticky_shift = sticky_q | guard_q;
  assign fin_guard    = in_shift & guard_shift;
  assign fin_sticky   = in_shift & sticky_shift;
  assign rnd_up       = fin_guard & (fin_sticky | fin_mag[0]);
  assign mag_rnd      = {1'b0, fin_mag} + {{OUT_W{1'b0}}, rnd_up};
  assign rnd_ovf      = fin_sign ? (mag_rnd > {1'b0, MIN_NEG}) : (mag_rnd > {1'b0, MAX_POS});

  always_comb begin
    fin_data = fin_sign ? -mag_rnd[OUT_W-1:0] : mag_rnd[OUT_W-1:0];
    fin_ovf  = 1'b0;
    if (rnd_ovf) begin
      fin_data = fin_sign ? MIN_NEG : MAX_POS;
      fin_ovf  = 1'b1;
    end
  end

  always_comb begin
    guard_d  = guard_q;
    sticky_d = sticky_q;
    if (state_q == ST_LOAD) begin
      guard_d  = 1'b0;
      sticky_d = 1'b0;
    end else if (in_shift) begin
      guard_d  = guard_shift;
      sticky_d = sticky_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
    end
  end
`else
  assign fin_data = fin_sign ? -fin_mag : fin_mag;
  assign fin_ovf  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    left_d  = left_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus_io.in_valid) begin
          word_d  = bus_io.in_data;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sign_d = word_q[31];
        mag_d  = mag_load;
        left_d = ~s_w[10];
        cnt_d  = '0;
        if (exp_w == 8'd0) begin
          data_d  = '0;
          ovf_d   = 1'b0;
          state_d = ST_DONE;
        end else if (exp_w == 8'hFF) begin
          data_d  = (frac_w != '0) ? '0 : (word_q[31] ? MIN_NEG : MAX_POS);
          ovf_d   = 1'b1;
          state_d = ST_DONE;
        end else if (s_w[10]) begin
          cnt_d   = (s_w < S_RMAX) ? N_RMAX : 6'(-s_w);
          state_d = ST_SHIFT;
        end else if ((s_w > S_MAX) &&
                     !(word_q[31] && (frac_w == '0) && (s_w == S_EXACT))) begin
          // -2^(OUT_W-1) is the one value one bit past the positive range that still fits.
          data_d  = word_q[31] ? MIN_NEG : MAX_POS;
          ovf_d   = 1'b1;
          state_d = ST_DONE;
        end else if (s_w == '0) begin
          data_d  = fin_data;
          ovf_d   = fin_ovf;
          state_d = ST_DONE;
        end else begin
          cnt_d   = 6'(s_w);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        mag_d = mag_shift;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          data_d  = fin_data;
          ovf_d   = fin_ovf;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus_io.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      left_q  <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      left_q  <= left_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus_io.in_ready  = (state_q == ST_IDLE);
  assign bus_io.out_valid = (state_q == ST_DONE);
  assign bus_io.out_data  = data_q;
  assign bus_io.out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_k_float2fix_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_k_float2fix_seq
// Purpose  : self-checking bench for k_float2fix_seq (OUT_W=32, FRAC_W=16).
// Revision : 1.0
// ============================================================================
module tb_k_float2fix_seq;

  localparam int OUT_W  = 32;
  localparam int FRAC_W = 16;
`ifdef K_FLOAT2FIX_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef struct {
    logic [31:0] w;
    logic [31:0] d;
    logic        o;
    int          n;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  k_float2fix_seq_if #(.OUT_W(OUT_W)) bus ();

  k_float2fix_seq #(
    .OUT_W (OUT_W),
    .FRAC_W(FRAC_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference: value = M * 2^(E-150), scaled by 2^FRAC_W, range-checked by value.
  function automatic void model(input logic [31:0] w, output logic [31:0] d,
                                output logic o, output int n);
    int     e;
    int     s;
    int     sh;
    longint m;
    longint v;
    longint g;
    longint st;
    logic   sg;
    sg = w[31];
    e  = int'(w[30:23]);
    m  = longint'({1'b1, w[22:0]});
    s  = e - 150 + FRAC_W;
    d  = '0;
    o  = 1'b0;
    n  = 0;
    if (e == 0) begin
      d = '0;
    end else if (e == 255) begin
      o = 1'b1;
      if (w[22:0] == 23'd0) d = sg ? 32'h80000000 : 32'h7FFFFFFF;
    end else if (s < 0) begin
      sh = -s;
      n  = (sh > 25) ? 25 : sh;
      if (sh >= 26) begin
        v = 0; g = 0; st = 0;
      end else begin
        v  = m >>> sh;
        g  = (m >>> (sh - 1)) & 64'sd1;
        st = m & ((64'sd1 <<< (sh - 1)) - 64'sd1);
      end
      if (RNE && (g != 0) && ((st != 0) || ((v & 64'sd1) != 0))) v = v + 1;
      d = sg ? 32'(-v) : 32'(v);
    end else begin
      v = (s > 40) ? 64'sd0 : (m <<< s);
      if ((s > 40) || (!sg && v > 64'sh7FFFFFFF) || (sg && v > 64'sh80000000)) begin
        o = 1'b1;
        d = sg ? 32'h80000000 : 32'h7FFFFFFF;
      end else begin
        n = s;
        d = sg ? 32'(-v) : 32'(v);
      end
    end
  endfunction

  task automatic send(input logic [31:0] w, input logic [31:0] d, input logic o, input int n);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (bus.in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (t >= 100) begin
      fails++;
      $display("FAIL accept_timeout w=%h in_ready=%b required 1", w, bus.in_ready);
    end
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    sb.push_back('{w: w, d: d, o: o, n: n});
  endtask

  // Latency counts the handshake cycle as cycle 0 and the first out_valid cycle as n+2.
  task automatic recv(input int hold);
    int   t;
    int   lat;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    lat = cyc - acc_cyc + 1;
    tests++;
    if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
      fails++;
      $display("FAIL out_valid_timeout out_valid=%b required 1 (sb=%0d)", bus.out_valid, sb.size());
      return;
    end
    e = sb.pop_front();
    tests++;
    if (bus.out_data !== e.d) begin
      fails++;
      $display("FAIL out_data w=%h got %h required %h", e.w, bus.out_data, e.d);
    end
    tests++;
    if (bus.out_ovf !== e.o) begin
      fails++;
      $display("FAIL out_ovf w=%h got %b required %b", e.w, bus.out_ovf, e.o);
    end
    tests++;
    if (lat != e.n + 2) begin
      fails++;
      $display("FAIL latency w=%h got %0d required %0d", e.w, lat, e.n + 2);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.d || bus.out_ovf !== e.o ||
          bus.in_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_stable cycle %0d valid=%b data=%h ovf=%b in_ready=%b required 1 %h %b 0",
                 i, bus.out_valid, bus.out_data, bus.out_ovf, bus.in_ready, e.d, e.o);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL out_valid_drop got %b required 0", bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready got %b required 1", bus.in_ready);
    end
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid got %b required 0", bus.out_valid);
    end
    tests++;
    if (bus.out_data !== '0) begin
      fails++; $display("FAIL reset_out_data got %h required 0", bus.out_data);
    end
    tests++;
    if (bus.out_ovf !== 1'b0) begin
      fails++; $display("FAIL reset_out_ovf got %b required 0", bus.out_ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    exp_t v[$];
    v.push_back('{w: 32'h3F800000, d: 32'h00010000, o: 1'b0, n: 7});
    v.push_back('{w: 32'hC0200000, d: 32'hFFFD8000, o: 1'b0, n: 6});
    v.push_back('{w: 32'h471C4000, d: 32'h7FFFFFFF, o: 1'b1, n: 0});
    v.push_back('{w: 32'hC7000000, d: 32'h80000000, o: 1'b0, n: 8});
    v.push_back('{w: 32'h7FC00000, d: 32'h00000000, o: 1'b1, n: 0});
    v.push_back('{w: 32'hFF800000, d: 32'h80000000, o: 1'b1, n: 0});
    v.push_back('{w: 32'h7F800000, d: 32'h7FFFFFFF, o: 1'b1, n: 0});
    v.push_back('{w: 32'h37C00000, d: RNE ? 32'h00000002 : 32'h00000001, o: 1'b0, n: 23});
    v.push_back('{w: 32'hB7C00000, d: RNE ? 32'hFFFFFFFE : 32'hFFFFFFFF, o: 1'b0, n: 23});
    v.push_back('{w: 32'h37000000, d: 32'h00000000, o: 1'b0, n: 24});
    v.push_back('{w: 32'h38200000, d: 32'h00000002, o: 1'b0, n: 22});
    v.push_back('{w: 32'h00000001, d: 32'h00000000, o: 1'b0, n: 0});
    v.push_back('{w: 32'h80000000, d: 32'h00000000, o: 1'b0, n: 0});
    v.push_back('{w: 32'h43000000, d: 32'h00800000, o: 1'b0, n: 0});
    v.push_back('{w: 32'h46FFFFFF, d: 32'h7FFFFF80, o: 1'b0, n: 7});
    v.push_back('{w: 32'h30000000, d: 32'h00000000, o: 1'b0, n: 25});
    foreach (v[i]) begin
      send(v[i].w, v[i].d, v[i].o, v[i].n);
      recv(0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    logic [31:0] d;
    logic        o;
    int          n;
    for (int i = 0; i < 24; i++) begin
      w = {1'(i[0]), 8'($urandom_range(100, 145)), 23'($urandom)};
      model(w, d, o, n);
      send(w, d, o, n);
      recv(0);
    end
  endtask

  task automatic test_backpressure();
    send(32'h3F800000, 32'h00010000, 1'b0, 7);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hC0200000;
    recv(5);
    send(32'hC0200000, 32'hFFFD8000, 1'b0, 6);
    recv(0);
  endtask

  task automatic test_reset_mid();
    logic spurious;
    spurious = 1'b0;
    @(negedge clk);
    send(32'h3F800000, 32'h00010000, 1'b0, 7);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.in_ready !== 1'b1 || bus.out_ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid valid=%b data=%h in_ready=%b ovf=%b required 0 0 1 0",
               bus.out_valid, bus.out_data, bus.in_ready, bus.out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) spurious = 1'b1;
    end
    tests++;
    if (spurious) begin
      fails++;
      $display("FAIL reset_mid_spurious got out_valid 1 required 0");
    end
    send(32'h3F800000, 32'h00010000, 1'b0, 7);
    recv(0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/k_float2fix_seq.md
Name: k_float2fix_seq

Overview:
- Multi-cycle converter from IEEE-754 single-precision float to signed two's-complement fixed point (Q format, FRAC_W fraction bits).
- Performs the reverse of the float adder's normalisation: it denormalises and aligns the mantissa.
- Sits between the float FFT datapath and the fixed-point output/DAC side.
- Uses a valid/ready handshake on both sides, handles one conversion at a time, and aligns by iterative single-bit shifting.

Parameters:
- OUT_W, 32: output width; legal range 25..64.
- FRAC_W, 16: fraction bits of the output; legal range 0..OUT_W-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a new input.
- in_data  input  32  IEEE-754 single-precision operand.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  OUT_W  signed fixed-point result.
- out_ovf  output  1  result saturated, or input was NaN.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_ovf=0.
- States:
  - IDLE: in_ready=1. An input is accepted when in_valid and in_ready are both high; go to LOAD.
  - LOAD (1 cycle): unpack the captured word. S=bit31, E=bits30:23, M={1,bits22:0}.
  - SHIFT: one bit of shift per cycle, n cycles total.
  - DONE: out_valid=1.
- LOAD special cases, all with n=0, going straight to DONE:
  - E=0 (zero or subnormal): result 0, ovf=0.
  - E=255 with mantissa bits nonzero (NaN): result 0, ovf=1.
  - E=255 with mantissa bits zero (Inf): saturate by sign, ovf=1.
- Shift amount: s = E - 150 + FRAC_W (signed, at least 10 bits).
- s<0: right shift, n = min(-s, 25). Truncates toward zero on magnitude. After 25 shifts the magnitude is 0.
- s>=0, overflow check:
  - Overflow when 24+s > OUT_W-1.
  - Exception: S=1, M=0x800000 and s = OUT_W-24 gives exactly -2^(OUT_W-1). This is not overflow.
  - On overflow: n=0, result 0x7FF..F (S=0) or 0x800..0 (S=1), ovf=1.
  - Otherwise left shift, n=s.
- Magnitude register is OUT_W bits wide. When the last shift completes (or at LOAD if n=0), out_data = S ? -mag : mag, registered on entry to DONE.
- Latency: out_valid rises n+2 cycles after the accepting edge.
- DONE: out_data and out_ovf are held stable until out_valid and out_ready are both high. On that edge go to IDLE and out_valid=0.
- No overlap: in_ready=0 in LOAD, SHIFT and DONE. A new input is accepted no earlier than the cycle after the output handshake.
- The shift counter counts down from n; SHIFT exits on the edge where the counter reaches 1.
- Negative zero gives 0. Any sign with a zero magnitude gives 0, ovf=0.
- rst_n asserted mid-operation: immediately return to the reset values. The in-flight conversion is discarded and no output is produced.
- in_valid held in any non-IDLE state is ignored.

Optional Feature:
- Macro: K_FLOAT2FIX_RNE_EN.
- When defined:
  - Right shifts track a guard bit (last bit shifted out) and a sticky bit (OR of earlier bits shifted out).
  - On entry to DONE, the magnitude is rounded half-to-even: +1 if guard && (sticky || mag[0]).
  - If rounding makes the magnitude exceed the range, saturate with ovf=1. This is -2^(OUT_W-1) when S=1.
  - Rounding adds no extra cycle.
- When undefined: truncate toward zero; no guard/sticky logic.

Test Plan (OUT_W=32, FRAC_W=16):
- 0x3F800000 (1.0) -> out_data=0x00010000, ovf=0, out_valid 9 cycles after accept (n=7).
- 0xC0200000 (-2.5) -> 0xFFFD8000, ovf=0, n=6.
- 0x471C4000 (40000.0) -> 0x7FFFFFFF, ovf=1, n=0. 0xC7000000 (-32768.0) -> 0x80000000, ovf=0, n=8. 0x7FC00000 (NaN) -> 0, ovf=1. 0xFF800000 (-Inf) -> 0x80000000, ovf=1.
- 0x37C00000 (1.5 LSB) -> 0x00000001 when truncating; 0x00000002 with K_FLOAT2FIX_RNE_EN. 0x00000001 (subnormal) and 0x80000000 (-0) -> 0, ovf=0.
- Backpressure: 1.0 converted, out_ready held low 5 cycles with in_valid high -> out_data stable at 0x00010000, in_ready=0. After the out_ready handshake, the next input is accepted and converted correctly.
- Reset mid-SHIFT: 0x3F800000 accepted, rst_n pulsed low on the 3rd SHIFT cycle -> out_valid=0, out_data=0, in_ready=1 immediately. No spurious output after release.
